// File: rtl/mips_cpu_reg_writeback.sv
// mips_cpu_reg_writeback: register-file write-port arbiter with load tracking and an ALU skid FIFO
module mips_cpu_reg_writeback #(
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    alu_valid,
    output logic                    alu_ready,
    input  logic [4:0]              alu_addr,
    input  logic [31:0]             alu_data,
    input  logic                    load_issue,
    input  logic [4:0]              load_issue_addr,
    input  logic                    load_valid,
    input  logic [31:0]             load_data,
    output logic                    load_busy,
    output logic [4:0]              pending_addr,
    output logic                    writeEnable,
    output logic [4:0]              writeAddress,
    output logic [31:0]             dataIn,
    output logic [$clog2(DEPTH):0]  fifo_count,
    output logic                    protocol_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    logic [4:0]    fifo_addr [DEPTH];
    logic [31:0]   fifo_data [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          load_win, fifo_ne, alu_acc, pop, bypass, push, sel_valid;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;
    assign alu_ready = fifo_count < CW'(DEPTH);
    assign alu_acc   = alu_valid && alu_ready;
    assign load_win  = load_valid && load_busy;
    assign fifo_ne   = fifo_count != '0;
    assign pop       = !load_win && fifo_ne;
    assign bypass    = !load_win && !fifo_ne && alu_acc;
    assign push      = alu_acc && !bypass;
    assign sel_valid = load_win || fifo_ne || alu_acc;
    assign sel_addr  = load_win ? pending_addr : fifo_ne ? fifo_addr[rd_ptr] : alu_addr;
    assign sel_data  = load_win ? load_data : fifo_ne ? fifo_data[rd_ptr] : alu_data;
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= alu_addr;
            fifo_data[wr_ptr] <= alu_data;
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            fifo_count   <= '0;
            load_busy    <= 1'b0;
            pending_addr <= '0;
            writeEnable  <= 1'b0;
            writeAddress <= '0;
            dataIn       <= '0;
            protocol_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            fifo_count  <= fifo_count + CW'(push) - CW'(pop);
            writeEnable <= sel_valid && sel_addr != 5'd0;
            if (sel_valid) begin
                writeAddress <= sel_addr;
                dataIn       <= sel_data;
            end
            if (load_issue && (!load_busy || load_valid)) begin
                load_busy    <= 1'b1;
                pending_addr <= load_issue_addr;
            end else if (load_win) begin
                load_busy <= 1'b0;
            end
            if ((load_issue && load_busy && !load_valid) || (load_valid && !load_busy)) protocol_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mips_cpu_reg_writeback.sv
// tb_mips_cpu_reg_writeback: directed and randomized checks against a queue-based reference model
module tb_mips_cpu_reg_writeback;
    localparam int DEPTH = 2;
    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready;
    logic [4:0]  alu_addr;
    logic [31:0] alu_data;
    logic        load_issue;
    logic [4:0]  load_issue_addr;
    logic        load_valid;
    logic [31:0] load_data;
    logic        load_busy;
    logic [4:0]  pending_addr;
    logic        writeEnable;
    logic [4:0]  writeAddress;
    logic [31:0] dataIn;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        protocol_err;
    int errors = 0;
    int checks = 0;
    logic [36:0] q[$];
    logic        m_busy, m_we, m_perr;
    logic [4:0]  m_paddr, m_wa;
    logic [31:0] m_din;

    mips_cpu_reg_writeback #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
        .load_issue(load_issue), .load_issue_addr(load_issue_addr),
        .load_valid(load_valid), .load_data(load_data),
        .load_busy(load_busy), .pending_addr(pending_addr),
        .writeEnable(writeEnable), .writeAddress(writeAddress), .dataIn(dataIn),
        .fifo_count(fifo_count), .protocol_err(protocol_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_busy = 0; m_we = 0; m_perr = 0; m_paddr = 0; m_wa = 0; m_din = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/we"}, 32'(writeEnable), 32'(m_we));
        chk({tag, "/wa"}, 32'(writeAddress), 32'(m_wa));
        chk({tag, "/din"}, dataIn, m_din);
        chk({tag, "/count"}, 32'(fifo_count), q.size());
        chk({tag, "/ready"}, 32'(alu_ready), 32'(q.size() < DEPTH));
        chk({tag, "/busy"}, 32'(load_busy), 32'(m_busy));
        chk({tag, "/paddr"}, 32'(pending_addr), 32'(m_paddr));
        chk({tag, "/perr"}, 32'(protocol_err), 32'(m_perr));
    endtask

    task automatic idle();
        alu_valid = 0; load_issue = 0; load_valid = 0;
    endtask

    task automatic step(input string tag);
        logic [36:0] w;
        bit wrote, acc;
        acc = alu_valid && (q.size() < DEPTH);
        wrote = 1;
        if (load_valid && m_busy) w = {m_paddr, load_data};
        else if (q.size() > 0) w = q.pop_front();
        else if (acc) begin w = {alu_addr, alu_data}; acc = 0; end
        else wrote = 0;
        if (acc) q.push_back({alu_addr, alu_data});
        m_we = wrote && w[36:32] != 5'd0;
        if (wrote) {m_wa, m_din} = w;
        if ((load_issue && m_busy && !load_valid) || (load_valid && !m_busy)) m_perr = 1;
        if (load_issue && (!m_busy || load_valid)) begin m_busy = 1; m_paddr = load_issue_addr; end
        else if (load_valid && m_busy) m_busy = 0;
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    initial begin
        reset = 0; alu_valid = 1; alu_addr = 5'd7; alu_data = 32'h1234;
        load_issue = 0; load_issue_addr = 0; load_valid = 0; load_data = 0;
        model_reset();
        repeat (3) begin @(posedge clk); #1; check_all("reset"); end
        reset = 1; idle();
        // bypass straight to the write port
        alu_valid = 1; alu_addr = 5'd5; alu_data = 32'hDEADBEEF;
        step("bypass");
        chk("bypass_we", 32'(writeEnable), 1);
        chk("bypass_wa", 32'(writeAddress), 5);
        chk("bypass_din", dataIn, 32'hDEADBEEF);
        idle(); step("idle");
        // load beats a simultaneous ALU result
        load_issue = 1; load_issue_addr = 5'd8; step("lp_issue");
        idle(); step("lp_wait");
        load_valid = 1; load_data = 32'h11; alu_valid = 1; alu_addr = 5'd3; alu_data = 32'h22;
        step("lp_ret");
        chk("lp_wa", 32'(writeAddress), 8);
        chk("lp_din", dataIn, 32'h11);
        chk("lp_count", 32'(fifo_count), 1);
        chk("lp_busy", 32'(load_busy), 0);
        idle(); step("lp_drain");
        chk("lp_wa2", 32'(writeAddress), 3);
        chk("lp_count2", 32'(fifo_count), 0);
        // back-to-back loads fill the FIFO
        load_issue = 1; load_issue_addr = 5'd9; step("bp_issue");
        load_valid = 1; load_data = 32'hAA; load_issue_addr = 5'd10;
        alu_valid = 1; alu_addr = 5'd1; alu_data = 32'h101; step("bp_1");
        load_issue = 0; load_data = 32'hBB; alu_addr = 5'd2; alu_data = 32'h102; step("bp_2");
        chk("bp_full_ready", 32'(alu_ready), 0);
        chk("bp_full_count", 32'(fifo_count), 2);
        load_valid = 0; alu_addr = 5'd3; alu_data = 32'h103; step("bp_3");
        chk("bp_pop_r1", 32'(writeAddress), 1);
        step("bp_4");
        chk("bp_pop_r2", 32'(writeAddress), 2);
        idle(); step("bp_5");
        chk("bp_pop_r3", 32'(writeAddress), 3);
        chk("bp_empty", 32'(fifo_count), 0);
        // register zero writes are swallowed
        alu_valid = 1; alu_addr = 5'd0; alu_data = 32'hFFFFFFFF; step("z_alu");
        chk("z_alu_we", 32'(writeEnable), 0);
        idle(); load_issue = 1; load_issue_addr = 5'd0; step("z_issue");
        idle(); load_valid = 1; load_data = 32'h5; step("z_ret");
        chk("z_ret_we", 32'(writeEnable), 0);
        chk("z_ret_busy", 32'(load_busy), 0);
        idle();
        // randomized legal traffic with producer hold
        for (int i = 0; i < 400; i++) begin
            if (!(alu_valid && q.size() >= DEPTH)) begin
                alu_valid = $urandom_range(0, 3) != 0;
                alu_addr  = 5'($urandom);
                alu_data  = $urandom;
            end
            if (m_busy) begin
                load_valid = $urandom_range(0, 2) == 0;
                load_issue = load_valid && $urandom_range(0, 1) == 1;
            end else begin
                load_valid = 0;
                load_issue = $urandom_range(0, 3) == 0;
            end
            load_issue_addr = 5'($urandom);
            load_data = $urandom;
            step("rand");
        end
        idle();
        repeat (4) step("flush");
        if (m_busy) begin load_valid = 1; step("flush_load"); idle(); end
        // protocol violation, then async reset with a full FIFO
        load_issue = 1; load_issue_addr = 5'd12; step("pe_issue");
        load_issue_addr = 5'd13; step("pe_dup");
        chk("pe_err", 32'(protocol_err), 1);
        chk("pe_paddr", 32'(pending_addr), 12);
        load_valid = 1; load_data = 32'h77; load_issue_addr = 5'd14;
        alu_valid = 1; alu_addr = 5'd4; alu_data = 32'h44; step("ar_1");
        load_issue = 0; load_data = 32'h88; alu_addr = 5'd5; alu_data = 32'h55; step("ar_2");
        chk("ar_full", 32'(fifo_count), 2);
        idle();
        #3 reset = 0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk); #1; reset = 1;
        repeat (4) step("post_rst");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mips_cpu_reg_writeback.md
Name: mips_cpu_reg_writeback

Overview:
- Write-side controller for the CPU register file: collects results from the single-cycle ALU path and the multi-cycle load path.
- Drives the register file's single write port (writeEnable/writeAddress/dataIn), at most one write per cycle.
- Buffers ALU results in a small skid FIFO while a load return owns the port.
- Tracks the one outstanding load destination so decode can detect hazards and stall.

Parameters:
DEPTH, 2, ALU skid FIFO entries (power of 2, >=2)

Ports:
clk  input  1  clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (low = reset asserted)
alu_valid  input  1  ALU result offered this cycle
alu_ready  output  1  FIFO can accept an ALU result
alu_addr  input  5  ALU destination register
alu_data  input  32  ALU result
load_issue  input  1  load instruction dispatched to memory
load_issue_addr  input  5  destination of dispatched load
load_valid  input  1  load data returning this cycle
load_data  input  32  returned load word
load_busy  output  1  a load is outstanding (pending_valid)
pending_addr  output  5  destination of outstanding load
writeEnable  output  1  register file write strobe
writeAddress  output  5  register file write address
dataIn  output  32  register file write data
fifo_count  output  $clog2(DEPTH)+1  occupied FIFO entries
protocol_err  output  1  sticky protocol-violation flag

Behaviour:
- Reset (async assert, sync release): writeEnable=0, writeAddress=0, dataIn=0, FIFO empty, fifo_count=0, load_busy=0, pending_addr=0, protocol_err=0. alu_ready reads 1 after reset.
- All write-port outputs are registered. A winning source at edge N is visible on writeEnable/writeAddress/dataIn after edge N, held for exactly one cycle.
- alu_ready = (fifo_count < DEPTH), combinational from state only; no dependence on alu_valid.
- ALU accept = alu_valid && alu_ready. When alu_valid && !alu_ready, the ALU result is not taken and the producer must hold it.
- Per-cycle arbitration, priority order:
  1. load_valid && load_busy: write {pending_addr, load_data}; clear load_busy.
  2. FIFO non-empty: pop head and write it.
  3. ALU accepted with FIFO empty: bypass, write {alu_addr, alu_data} directly; no push.
- An ALU result accepted but not written this cycle is pushed at the tail. Push and pop in the same cycle is allowed; fifo_count is unchanged.
- ALU results retire in acceptance order. A load retires whenever it returns.
- Register 0: any selected write with address 0 is consumed normally (popped, pending cleared) but forces writeEnable=0. dataIn/writeAddress still update.
- load_issue with !load_busy: pending_addr <= load_issue_addr, load_busy <= 1.
- load_issue && load_valid in the same cycle: the old load retires and the new load is captured, so load_busy stays 1.
- load_issue while load_busy and no load_valid: issue ignored, protocol_err <= 1.
- load_valid while !load_busy: ignored, no write, protocol_err <= 1.
- protocol_err clears only on reset.
- Reset mid-operation: FIFO contents and the pending load are discarded immediately; no write is issued after reset deasserts until a new source arrives.
- FIFO pointers wrap modulo DEPTH.
- Full-FIFO and load return in the same cycle: the load writes, nothing pops, alu_ready stays 0. No overflow is possible.

Test Plan:
- Reset: hold reset=0 for 3 cycles with alu_valid=1 -> writeEnable=0, fifo_count=0, alu_ready=1, load_busy=0, protocol_err=0.
- Bypass: alu_valid, addr=5, data=0xDEADBEEF -> next cycle writeEnable=1, writeAddress=5, dataIn=0xDEADBEEF; fifo_count stays 0.
- Load priority: issue load to r8; later load_valid (data 0x11) in the same cycle as ALU r3=0x22 -> cycle+1 write r8=0x11 and fifo_count=1; cycle+2 write r3=0x22 and fifo_count=0; load_busy drops after the load edge.
- Backpressure/wrap: load returns and ALU writes r1, r2, r3 on consecutive cycles with DEPTH=2 -> alu_ready=0 once fifo_count=2; r3 is accepted after the first pop; writes appear in order r1, r2, r3; push/pop across the wrap point is exercised ≥3 times.
- $zero: ALU addr=0 data=0xFFFFFFFF, then load to r0 returning 0x5 -> writeEnable stays 0 both cycles; load_busy clears.
- Protocol and async reset: second load_issue while busy -> protocol_err=1, pending_addr unchanged. Assert reset between clock edges with fifo_count=2 -> outputs zero immediately; no writes follow release.
